// File: rtl/stream_cipher_pkg.sv
// Shared types for the stream cipher datapath: output holder state,
// interface state and the byte width used across the cipher core.
package stream_cipher_pkg;

  localparam int BYTE_W = 8;

  // Holder state presented to the output mux; 2'b11 is never produced.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    READY = 2'b01,
    ACKED = 2'b10
  } output_holder_state_t;

  // Chip interface state shared by the host-facing blocks.
  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_LOAD = 2'b01,
    IF_RUN  = 2'b10,
    IF_DONE = 2'b11
  } interface_state_t;

endpackage

// File: rtl/output_holder_ack_sync_edge.sv
// ack_sync_edge: multi-flop synchroniser for an asynchronous pin plus a
// rising-edge detector on the synchronised level. Reusable for any slow
// asynchronous input; level_s lags the pin by SYNC_STAGES cycles.
module ack_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level_s,
  output logic rise_s
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   level_d;

  // Shift the raw pin through the synchroniser chain and keep a delayed copy
  // of the synchronised level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
      level_d   <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], async_in};
      level_d   <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign level_s = sync_pipe[SYNC_STAGES-1];
  assign rise_s  = level_s & ~level_d;

endmodule

// File: rtl/output_holder.sv
// output_holder: holds one finished cipher byte until the user acknowledges
// it with a four-phase handshake on the asynchronous output_acknowledge pin.
// Ack rise retires the byte (READY -> ACKED); ack fall frees the holder.
// Optional macro OUTPUT_HOLDER_SKID_EN adds a one-byte skid register so the
// upstream can queue the next byte while the current one is being read.
module output_holder
  import stream_cipher_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 output_acknowledge,
  output logic [BYTE_W-1:0]    data_out,
  output output_holder_state_t output_holder_state
);

  logic ack_s;
  logic ack_rise;
  logic accept;

  ack_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (output_acknowledge),
    .level_s  (ack_s),
    .rise_s   (ack_rise)
  );

  assign accept = in_valid & in_ready;

`ifdef OUTPUT_HOLDER_SKID_EN

  logic [BYTE_W-1:0] skid;
  logic              skid_valid;
  logic              release_ack;

  // Holder frees up this cycle: ack has fallen while ACKED.
  assign release_ack = (output_holder_state == ACKED) & ~ack_s;
  assign in_ready    = ~skid_valid;

  // Holder FSM with skid: a queued byte moves straight into data_out on
  // release so the output never shows an EMPTY gap between bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_holder_state <= EMPTY;
      data_out            <= '0;
      skid                <= '0;
      skid_valid          <= 1'b0;
    end else begin
      case (output_holder_state)
        EMPTY: begin
          if (accept) begin
            data_out            <= in_data;
            output_holder_state <= READY;
          end
        end
        READY: begin
          if (accept) begin
            skid       <= in_data;
            skid_valid <= 1'b1;
          end
          if (ack_rise) output_holder_state <= ACKED;
        end
        ACKED: begin
          if (release_ack && skid_valid) begin
            data_out            <= skid;
            output_holder_state <= READY;
            skid_valid          <= accept;
            if (accept) skid <= in_data;
          end else if (release_ack && accept) begin
            // Nothing queued; the incoming byte goes straight to the output.
            data_out            <= in_data;
            output_holder_state <= READY;
          end else if (release_ack) begin
            output_holder_state <= EMPTY;
          end else if (accept) begin
            skid       <= in_data;
            skid_valid <= 1'b1;
          end
        end
        default: output_holder_state <= EMPTY;
      endcase
    end
  end

`else

  assign in_ready = (output_holder_state == EMPTY);

  // Single-entry holder FSM: accept only when EMPTY, retire on a fresh ack
  // rise, free once the synchronised ack returns low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_holder_state <= EMPTY;
      data_out            <= '0;
    end else begin
      case (output_holder_state)
        EMPTY: begin
          if (accept) begin
            data_out            <= in_data;
            output_holder_state <= READY;
          end
        end
        READY:   if (ack_rise) output_holder_state <= ACKED;
        ACKED:   if (!ack_s)   output_holder_state <= EMPTY;
        default: output_holder_state <= EMPTY;
      endcase
    end
  end

`endif

endmodule
